// File: rtl/riscv_mem_wb_stage.sv
// Combined MEM/WB stage for an in-order RV32I pipeline: one instruction in flight,
// a local byte-addressable data memory with configurable latency, and the register-file write port.
module riscv_mem_wb_stage #(
    parameter int MEM_LAT = 2,
    parameter int DEPTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        accept, mem_fire;

    logic [6:0]  op_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] res_q;
    logic [31:0] sd_q;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   rd_word, ld_data, st_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic          is_load_q, is_store_q, acc_err;

    logic          we_q, err_q;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic writes_reg(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LUI) ||
               (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ex_ready  = 1'b0;
        accept    = 1'b0;
        mem_fire  = 1'b0;
        case (state)
            IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid) begin
                    accept = 1'b1;
                    if (is_mem_op(ex_opcode)) begin
                        state_nxt = ACCESS;
                        cnt_nxt   = 3'(MEM_LAT - 1);
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            ACCESS: begin
                if (cnt == 3'd0) begin
                    mem_fire  = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            f3_q  <= '0;
            rd_q  <= '0;
            res_q <= '0;
            sd_q  <= '0;
        end else if (accept) begin
            op_q  <= ex_opcode;
            f3_q  <= ex_funct3;
            rd_q  <= ex_rd;
            res_q <= ex_result;
            sd_q  <= ex_store_data;
        end
    end

    assign is_load_q  = (op_q == OP_LOAD);
    assign is_store_q = (op_q == OP_STORE);
    assign idx        = res_q[AW+1:2];
    assign rd_word    = mem[idx];

    always_comb begin
        acc_err = 1'b0;
        if (is_load_q) begin
            case (f3_q)
                3'b000, 3'b100: acc_err = 1'b0;
                3'b001, 3'b101: acc_err = res_q[0];
                3'b010:         acc_err = (res_q[1:0] != 2'b00);
                default:        acc_err = 1'b1;
            endcase
        end else if (is_store_q) begin
            case (f3_q)
                3'b000:  acc_err = 1'b0;
                3'b001:  acc_err = res_q[0];
                3'b010:  acc_err = (res_q[1:0] != 2'b00);
                default: acc_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (res_q[1:0])
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = res_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = '0;
        endcase
    end

    // Stores merge into the current word so untouched byte lanes keep their contents.
    always_comb begin
        st_word = rd_word;
        case (f3_q)
            3'b000:  st_word[{res_q[1:0], 3'b000} +: 8]  = sd_q[7:0];
            3'b001:  st_word[{res_q[1], 4'b0000} +: 16]  = sd_q[15:0];
            3'b010:  st_word = sd_q;
            default: st_word = rd_word;
        endcase
    end

    // NOTE: the data memory is reset word by word because reset must leave it all-zero, not just the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_fire && is_store_q && !acc_err) begin
            mem[idx] <= st_word;
        end
    end

    // Writeback registers load only when entering RESP, so wb_rd/wb_data hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd   <= '0;
            wb_data <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept && !is_mem_op(ex_opcode)) begin
            wb_rd   <= ex_rd;
            wb_data <= ex_result;
            we_q    <= writes_reg(ex_opcode) && (ex_rd != 5'd0);
            err_q   <= 1'b0;
        end else if (mem_fire) begin
            wb_rd   <= rd_q;
            wb_data <= is_load_q ? ld_data : res_q;
            we_q    <= is_load_q && !acc_err && (rd_q != 5'd0);
            err_q   <= acc_err;
        end
    end

    assign wb_valid = (state == RESP);
    assign wb_we    = wb_valid && we_q;
    assign mem_err  = wb_valid && err_q;

endmodule

// File: tb/tb_riscv_mem_wb_stage.sv
// Scoreboard bench for riscv_mem_wb_stage: a byte-array reference model predicts each response,
// and a negedge monitor checks every wb_valid pulse against the queued expectation and its cycle.
module tb_riscv_mem_wb_stage;

    localparam int MEM_LAT = 2;
    localparam int DEPTH   = 32;
    localparam int NBYTES  = 4 * DEPTH;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        bit          chk;
    } exp_t;

    exp_t         sb[$];
    byte unsigned mem_b [NBYTES];
    int           cyc    = 0;
    int           n_cmp  = 0;
    int           n_fail = 0;

    riscv_mem_wb_stage #(.MEM_LAT(MEM_LAT), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_opcode     (ex_opcode),
        .ex_funct3     (ex_funct3),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void clear_model();
        for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
    endfunction

    // Reference: architectural RV32I load/store semantics on a little-endian byte array.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                   input logic [31:0] res, input logic [31:0] sd);
        exp_t   e;
        int     a, size;
        bit     ld, st, bad, zext;
        longint v;
        ld   = (op == OP_LOAD);
        st   = (op == OP_STORE);
        a    = int'(res % NBYTES);
        zext = (f3 == 3'd4) || (f3 == 3'd5);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        bad = 1'b0;
        if (ld) bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        if (st) bad = (f3 > 3'd2);
        if ((ld || st) && !bad && (a % size) != 0) bad = 1'b1;
        e.cyc  = 0;
        e.rd   = rd;
        e.data = res;
        e.err  = (ld || st) && bad;
        e.chk  = 1'b1;
        if (ld && !bad) begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(mem_b[a + i]) << (8 * i);
            if (!zext && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
            e.data = v[31:0];
        end
        if (ld && bad) e.chk = 1'b0;
        if (st && !bad) begin
            for (int i = 0; i < size; i++) mem_b[a + i] = 8'(sd >> (8 * i));
        end
        e.we = (rd != 5'd0) && ((ld && !bad) || op == OP_R || op == OP_I || op == OP_LUI ||
                                op == OP_AUIPC || op == OP_JAL || op == OP_JALR);
        return e;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] sd,
                        input bit use_want, input logic [31:0] want);
        exp_t e;
        int   n;
        n = 0;
        while (ex_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ex_ready_before_send", ex_ready, 1'b1);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_result     = res;
        ex_store_data = sd;
        e = model(op, f3, rd, res, sd);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        e.cyc = cyc + (((op == OP_LOAD) || (op == OP_STORE)) ? MEM_LAT : 0);
        if (use_want) begin
            e.data = want;
            e.chk  = 1'b1;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wb_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wb_cycle", cyc, e.cyc);
                check("wb_we", wb_we, e.we);
                check("wb_rd", wb_rd, e.rd);
                check("mem_err", mem_err, e.err);
                if (e.chk) check("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, r;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] res;
        rst           = 1'b1;
        ex_valid      = 1'b0;
        ex_opcode     = '0;
        ex_funct3     = '0;
        ex_rd         = '0;
        ex_result     = '0;
        ex_store_data = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ex_ready", ex_ready, 1'b1);
        check("reset_wb_valid", wb_valid, 1'b0);
        check("reset_wb_data", wb_data, 32'h0);
        rst = 1'b0;
        #1;
        check("post_reset_ex_ready", ex_ready, 1'b1);
        @(posedge clk); #1;

        // ADD result, one cycle to writeback
        send(OP_R, 3'd0, 5'd5, 32'h0000_0007, 32'h0, 1'b1, 32'h0000_0007);
        // Store then sub-word loads
        send(OP_STORE, 3'd2, 5'd0, 32'h10, 32'h8765_4321, 1'b0, 32'h0);
        send(OP_LOAD, 3'd0, 5'd1, 32'h12, 32'h0, 1'b1, 32'h0000_0065);
        send(OP_LOAD, 3'd1, 5'd2, 32'h12, 32'h0, 1'b1, 32'hFFFF_8765);
        send(OP_LOAD, 3'd5, 5'd3, 32'h12, 32'h0, 1'b1, 32'h0000_8765);
        // Byte-lane merge
        send(OP_STORE, 3'd0, 5'd0, 32'h11, 32'h0000_00AA, 1'b0, 32'h0);
        send(OP_LOAD, 3'd2, 5'd4, 32'h10, 32'h0, 1'b1, 32'h8765_AA21);
        // Errors: misaligned LW, misaligned SH leaves memory alone
        send(OP_LOAD, 3'd2, 5'd6, 32'h06, 32'h0, 1'b0, 32'h0);
        send(OP_STORE, 3'd2, 5'd0, 32'h00, 32'h1122_3344, 1'b0, 32'h0);
        send(OP_STORE, 3'd1, 5'd0, 32'h03, 32'h0000_BEEF, 1'b0, 32'h0);
        send(OP_LOAD, 3'd2, 5'd7, 32'h00, 32'h0, 1'b1, 32'h1122_3344);
        // rd=0 suppresses write; address wraps modulo 4*DEPTH
        send(OP_LOAD, 3'd2, 5'd0, 32'h10, 32'h0, 1'b1, 32'h8765_AA21);
        send(OP_STORE, 3'd2, 5'd0, 32'h80, 32'hCAFE_F00D, 1'b0, 32'h0);
        send(OP_LOAD, 3'd2, 5'd8, 32'h00, 32'h0, 1'b1, 32'hCAFE_F00D);

        // Reset one cycle after accepting a store
        send(OP_STORE, 3'd2, 5'd0, 32'h20, 32'h5555_AAAA, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_we", wb_we, 1'b0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_ex_ready", ex_ready, 1'b1);
        sb.delete();
        clear_model();
        @(posedge clk); #1;
        check("rst_held_ex_ready", ex_ready, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_release_ex_ready", ex_ready, 1'b1);
        @(posedge clk); #1;
        send(OP_LOAD, 3'd2, 5'd9, 32'h20, 32'h0, 1'b1, 32'h0);
        send(OP_LOAD, 3'd2, 5'd10, 32'h10, 32'h0, 1'b1, 32'h0);

        // Randomized traffic against the model
        for (int t = 0; t < 300; t++) begin
            r   = int'($urandom_range(0, 9));
            res = $urandom;
            f3  = 3'($urandom_range(0, 7));
            case (r)
                0, 1, 2: op = OP_LOAD;
                3, 4:    op = OP_STORE;
                5:       op = OP_R;
                6:       op = OP_I;
                7: begin
                    case ($urandom_range(0, 3))
                        0:       op = OP_LUI;
                        1:       op = OP_AUIPC;
                        2:       op = OP_JAL;
                        default: op = OP_JALR;
                    endcase
                end
                8:       op = OP_BR;
                default: op = 7'($urandom);
            endcase
            if ((op == OP_LOAD || op == OP_STORE) && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'd0;
                    1:       f3 = 3'd1;
                    2:       f3 = 3'd2;
                    3:       f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
                if ($urandom_range(0, 1) != 0) res[1:0] = 2'b00;
            end
            send(op, f3, 5'($urandom_range(0, 31) & ($urandom_range(0, 4) == 0 ? 0 : 31)),
                 res, $urandom, 1'b0, 32'h0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
